// File: rtl/nand_flash_ctrl.sv
// Host-side NAND flash command sequencer: READ, PROGRAM with write/verify retry, and timed ERASE.
// Only one command is in flight at a time. Every output except cmd_ready is registered.
module nand_flash_ctrl #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int ERASE_CYCLES = 16,
  parameter int MAX_RETRY    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic              mem_we,
  output logic              mem_re,
  output logic              mem_erase,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(ERASE_CYCLES + 1);
  localparam int ATT_W = $clog2(MAX_RETRY + 1);

  typedef enum logic [3:0] {
    IDLE, RD_ISSUE, RD_CAP, PG_WRITE, PG_VRD, PG_CMP, ER_ISSUE, ER_WAIT, RESP
  } state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  wait_cnt, wait_cnt_n;
  logic [ATT_W-1:0]  attempt, attempt_n;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] wdata_n;
  logic [DATA_W-1:0] rdata_n;
  logic              err_n;
  logic              rvalid_n;

  assign cmd_ready = (state == IDLE);

  always_comb begin
    state_n    = state;
    wait_cnt_n = wait_cnt;
    attempt_n  = attempt;
    addr_n     = mem_addr;
    wdata_n    = mem_wdata;
    rdata_n    = rsp_rdata;
    err_n      = rsp_err;
    rvalid_n   = rsp_valid;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          addr_n    = cmd_addr;
          wdata_n   = cmd_wdata;
          attempt_n = ATT_W'(1);
          rdata_n   = '0;
          err_n     = 1'b0;
          case (cmd_op)
            2'b00:   state_n = RD_ISSUE;
            2'b01:   state_n = PG_WRITE;
            2'b10:   state_n = ER_ISSUE;
            default: begin
              // Reserved opcode is answered immediately without touching memory.
              state_n  = RESP;
              err_n    = 1'b1;
              rvalid_n = 1'b1;
            end
          endcase
        end
      end
      RD_ISSUE: state_n = RD_CAP;
      RD_CAP: begin
        rdata_n  = mem_rdata;
        rvalid_n = 1'b1;
        state_n  = RESP;
      end
      PG_WRITE: state_n = PG_VRD;
      PG_VRD:   state_n = PG_CMP;
      PG_CMP: begin
        if (mem_rdata == mem_wdata) begin
          rdata_n  = mem_rdata;
          rvalid_n = 1'b1;
          state_n  = RESP;
        end else if (attempt < ATT_W'(MAX_RETRY)) begin
          attempt_n = attempt + ATT_W'(1);
          state_n   = PG_WRITE;
        end else begin
          rdata_n  = mem_rdata;
          err_n    = 1'b1;
          rvalid_n = 1'b1;
          state_n  = RESP;
        end
      end
      ER_ISSUE: begin
        wait_cnt_n = CNT_W'(ERASE_CYCLES);
        state_n    = ER_WAIT;
      end
      ER_WAIT: begin
        // Counter is loaded with ERASE_CYCLES, so the last wait cycle sees a value of 1.
        if (wait_cnt == CNT_W'(1)) begin
          wait_cnt_n = '0;
          rvalid_n   = 1'b1;
          state_n    = RESP;
        end else begin
          wait_cnt_n = wait_cnt - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rvalid_n = 1'b0;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Strobes and status are registered from the next state so each strobe lines up with its state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      attempt   <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      mem_erase <= 1'b0;
      busy      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      state     <= state_n;
      wait_cnt  <= wait_cnt_n;
      attempt   <= attempt_n;
      mem_we    <= (state_n == PG_WRITE);
      mem_re    <= (state_n == RD_ISSUE) || (state_n == PG_VRD);
      mem_erase <= (state_n == ER_ISSUE);
      busy      <= (state_n != IDLE);
      mem_addr  <= addr_n;
      mem_wdata <= wdata_n;
      rsp_rdata <= rdata_n;
      rsp_err   <= err_n;
      rsp_valid <= rvalid_n;
    end
  end

endmodule
